// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter
//   Load/store unit sitting between the memory-access stage and a 32-bit
//   req/ack data bus. A single-cycle core request becomes one bus
//   transaction with byte-lane steering on the way out and lane
//   extraction plus sign/zero extension on the way back. Misaligned
//   accesses, illegal funct3 codes and bus timeouts raise a one-cycle
//   fault. The core is held with 'stall' while a transaction is pending.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   mem_rd, mem_wr        core load/store request (held while stall=1)
//   mem_ctrl[2:0]         funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr[31:0]            byte address
//   wdata[31:0]           store data
//   rdata[31:0]           extended load data (registered)
//   stall                 core must hold its request while high
//   fault                 one-cycle pulse on illegal request or timeout
//   bus_req/we/addr/be/wdata  bus request side (registered)
//   bus_rdata, bus_ack    bus response side
module lsu_bus_adapter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic            start;
    logic            illegal;
    logic            timeout_hit;
    logic [TO_W-1:0] cnt;
    logic [1:0]      off_q;
    logic [2:0]      ctrl_q;

    // Byte enables: size from funct3[1:0], shifted into the addressed lane.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes so the slave can pick any.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Extract the addressed lane and extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] off,
                                             input logic [2:0] ctrl);
        logic [31:0] lane;
        lane = d >> {off, 3'b000};
        case (ctrl)
            3'b000:  return {{24{lane[7]}}, lane[7:0]};
            3'b001:  return {{16{lane[15]}}, lane[15:0]};
            3'b100:  return {24'd0, lane[7:0]};
            3'b101:  return {16'd0, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    // Request classification
    always_comb begin
        start   = mem_rd | mem_wr;
        illegal = 1'b0;
        if (mem_rd && mem_wr)
            illegal = 1'b1;
        if (mem_ctrl == 3'b011 || mem_ctrl == 3'b110 || mem_ctrl == 3'b111)
            illegal = 1'b1;
        if (mem_wr && mem_ctrl[2])
            illegal = 1'b1;
        if (mem_ctrl[1:0] == 2'b01 && addr[0])
            illegal = 1'b1;
        if (mem_ctrl[1:0] == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;
    end

    assign timeout_hit = (state == REQ) && !bus_ack && (cnt == TO_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and stall
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start)
                    state_nx = illegal ? DONE : REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ack || timeout_hit)
                    state_nx = DONE;
            end
            // DONE never looks at the request, so the one still held by the
            // core on this cycle is not accepted a second time.
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs, load data, fault and timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata     <= '0;
            fault     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            cnt       <= '0;
            off_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (illegal) begin
                            fault <= 1'b1;
                            rdata <= '0;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_wr;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= lane_be(mem_ctrl[1:0], addr[1:0]);
                            bus_wdata <= lane_wdata(mem_ctrl[1:0], wdata);
                            off_q     <= addr[1:0];
                            ctrl_q    <= mem_ctrl;
                            cnt       <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we)
                            rdata <= load_ext(bus_rdata, off_q, ctrl_q);
                    end else if (cnt == TO_LAST) begin
                        bus_req <= 1'b0;
                        fault   <= 1'b1;
                        rdata   <= '0;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
module tb_lsu_bus_adapter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr;
    logic [2:0]  mem_ctrl;
    logic [31:0] addr, wdata, rdata;
    logic        stall, fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    lsu_bus_adapter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ctrl(mem_ctrl), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] brd;
        int          dly;   // REQ cycles before ack; >= TIMEOUT means no ack
        logic        ill;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rdv;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: derives the whole transaction outcome from the access
    // rules using plain arithmetic.
    function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] ctrl,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] brd, input int dly,
                                   input logic [31:0] prev);
        vec_t v;
        int nb, off, sz;
        longint lane, val;
        v.rd = rd; v.wr = wr; v.ctrl = ctrl; v.a = a; v.wd = wd; v.brd = brd; v.dly = dly;
        sz  = int'(ctrl) % 4;
        nb  = 1 << sz;
        off = int'(a % 4);
        v.ill = (rd && wr) || ctrl == 3 || ctrl == 6 || ctrl == 7 ||
                (wr && ctrl >= 4) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
        v.be  = 4'(((1 << nb) - 1) << off);
        if (nb == 1)      v.bwd = (wd & 32'hFF) * 32'h0101_0101;
        else if (nb == 2) v.bwd = (wd & 32'hFFFF) * 32'h0001_0001;
        else              v.bwd = wd;
        lane = longint'(brd) >> (8 * off);
        val  = lane % (64'd1 << (8 * nb));
        if (ctrl < 4 && nb < 4 && val >= (64'd1 << (8 * nb - 1)))
            val = val - (64'd1 << (8 * nb));
        if (v.ill || dly >= TIMEOUT) v.rdv = 32'd0;
        else if (wr)                 v.rdv = prev;
        else                         v.rdv = 32'(val);
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge+1 with it idle.
    task automatic run_access(input vec_t v);
        logic exp_fault;
        exp_fault = v.ill || (v.dly >= TIMEOUT);
        mem_rd = v.rd; mem_wr = v.wr; mem_ctrl = v.ctrl; addr = v.a; wdata = v.wd;
        bus_ack = 1'b1;              // stray ack while IDLE must be ignored
        bus_rdata = ~v.brd;
        #1 chk("stall_on_request", 32'(stall), 32'd1);
        @(negedge clk);
        bus_ack = 1'b0;
        if (!v.ill) begin
            chk("bus_we", 32'(bus_we), 32'(v.wr));
            chk("bus_addr", bus_addr, v.a & 32'hFFFF_FFFC);
            chk("bus_be", 32'(bus_be), 32'(v.be));
            if (v.wr) chk("bus_wdata", bus_wdata, v.bwd);
            for (int k = 0; k < TIMEOUT; k++) begin
                chk("bus_req_held", 32'(bus_req), 32'd1);
                chk("stall_in_req", 32'(stall), 32'd1);
                if (k == v.dly) begin
                    bus_ack = 1'b1;
                    bus_rdata = v.brd;
                end
                @(negedge clk);
                bus_ack = 1'b0;
                bus_rdata = $urandom;
                if (k == v.dly) break;
            end
        end
        // DONE cycle: request still held by the core
        chk("fault_pulse", 32'(fault), 32'(exp_fault));
        chk("rdata", rdata, v.rdv);
        chk("stall_done", 32'(stall), 32'd0);
        chk("bus_req_done", 32'(bus_req), 32'd0);
        @(negedge clk);
        chk("no_reaccept_req", 32'(bus_req), 32'd0);
        chk("fault_cleared", 32'(fault), 32'd0);
        mem_rd = 1'b0; mem_wr = 1'b0;
        #1 chk("stall_idle", 32'(stall), 32'd0);
        last_rdata = v.rdv;
    endtask

    vec_t vecs[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int r;
        //            rd wr ctrl   addr          wdata          bus_rdata      dly ill be       bus_wdata      rdata
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,         32'hDEADBEEF, 0,  1'b0, 4'b1111, 32'h0,         32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,         32'h80112233, 0,  1'b0, 4'b1000, 32'h0,         32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,         32'h80112233, 1,  1'b0, 4'b1000, 32'h0,         32'h00000080};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h022, 32'h1234ABCD, 32'h0,         0,  1'b0, 4'b1100, 32'hABCDABCD, 32'h00000080};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,         32'h0,         0,  1'b1, 4'b0000, 32'h0,         32'h00000000};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,         32'h80011234, 2,  1'b0, 4'b1100, 32'h0,         32'hFFFF8001};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,         32'h1234F00D, 0,  1'b0, 4'b0011, 32'h0,         32'h0000F00D};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h0000AA55, 32'h0,         1,  1'b0, 4'b0010, 32'h55555555, 32'h0000F00D};
        vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,         32'h0,         0,  1'b1, 4'b0000, 32'h0,         32'h00000000};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h108, 32'h0,         32'h11223344, 3,  1'b0, 4'b1111, 32'h0,         32'h11223344};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h10C, 32'h0,         32'h55667788, 99, 1'b0, 4'b1111, 32'h0,         32'h00000000};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h110, 32'h0,         32'h0,         0,  1'b1, 4'b0000, 32'h0,         32'h00000000};
        vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h110, 32'h000000FF, 32'h0,         0,  1'b1, 4'b0000, 32'h0,         32'h00000000};

        reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_ctrl = 3'b000;
        addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        last_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_bus_req", 32'(bus_req), 32'd0);
        chk("reset_bus_we", 32'(bus_we), 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_bus_be", 32'(bus_be), 32'd0);
        chk("reset_bus_wdata", bus_wdata, 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            run_access(vecs[i]);

        // Reset in the third REQ wait cycle, then a late ack, then a normal load.
        run_access(model(1'b1, 1'b0, 3'b010, 32'h1F0, 32'h0, 32'hA5A5_0F0F, 0, last_rdata));
        mem_rd = 1'b1; mem_ctrl = 3'b010; addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_bus_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_bus_req", 32'(bus_req), 32'd0);
        chk("async_reset_rdata", rdata, 32'd0);
        chk("async_reset_stall_idle", 32'(stall), 32'd1);
        mem_rd = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
        #1 chk("reset_state_idle", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("late_ack_bus_req", 32'(bus_req), 32'd0);
        chk("late_ack_rdata", rdata, 32'd0);
        chk("late_ack_fault", 32'(fault), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        bus_ack = 1'b0;
        last_rdata = 32'd0;
        run_access(model(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h13572468, 0, last_rdata));

        // Randomized accesses against the model
        for (int i = 0; i < 200; i++) begin
            logic rd, wr;
            int dly;
            r = $urandom_range(0, 9);
            rd = (r == 0) || (r < 6);
            wr = (r == 0) || (r >= 6);
            dly = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 4);
            v = model(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      dly, last_rdata);
            run_access(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
